// File: rtl/dmac_sched_pkg.sv
// Shared types for the DMAC request scheduler: FSM state and the descriptor payload.
package dmac_sched_pkg;

    localparam int unsigned DESC_ADDR_W = 32;
    localparam int unsigned DESC_LEN_W  = 24;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src_addr;
        logic [DESC_ADDR_W-1:0] dest_addr;
        logic [DESC_LEN_W-1:0]  x_length;
        logic                   last;
    } desc_t;

endpackage

// File: rtl/dmac_sched_id_fifo.sv
// In-order FIFO of requester IDs for issued-but-not-completed transfers.
module dmac_sched_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ID_W-1:0]          push_id,
    input  logic                     pop,
    output logic [ID_W-1:0]          head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmac_request_scheduler.sv
// Round-robin sharing of one axi_dmac request port among NUM_REQ requesters,
// with in-order routing of end-of-transfer pulses back to their owners.
module dmac_request_scheduler
    import dmac_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned DMA_AXI_ADDR_WIDTH = DESC_ADDR_W,
    parameter int unsigned DMA_LENGTH_WIDTH   = DESC_LEN_W,
    parameter int unsigned MAX_OUTSTANDING    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*DMA_AXI_ADDR_WIDTH-1:0] req_src_addr,
    input  logic [NUM_REQ*DMA_AXI_ADDR_WIDTH-1:0] req_dest_addr,
    input  logic [NUM_REQ*DMA_LENGTH_WIDTH-1:0]   req_x_length,
    input  logic [NUM_REQ-1:0]                    req_last,
    output logic [NUM_REQ-1:0]                    req_eot,
    output logic                                  request_valid,
    input  logic                                  request_ready,
    output logic [DMA_AXI_ADDR_WIDTH-1:0]         request_src_addr,
    output logic [DMA_AXI_ADDR_WIDTH-1:0]         request_dest_addr,
    output logic [DMA_LENGTH_WIDTH-1:0]           request_x_length,
    output logic                                  request_last,
    input  logic                                  request_eot,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  eot_error
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned AW   = DMA_AXI_ADDR_WIDTH;
    localparam int unsigned LW   = DMA_LENGTH_WIDTH;

    sched_state_t    state;
    logic [ID_W-1:0] last_grant;
    desc_t           desc_q;
    desc_t           sel_desc_c;
    logic            grant_c;
    logic [ID_W-1:0] grant_id_c;
    logic [ID_W-1:0] idx_c;
    logic            eot_pop_c;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        grant_c    = 1'b0;
        grant_id_c = '0;
        idx_c      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_c = ID_W'((32'(last_grant) + i) % NUM_REQ);
            if (!grant_c && req_valid[idx_c] && state == IDLE && !fifo_full && !reset) begin
                grant_c    = 1'b1;
                grant_id_c = idx_c;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
    end

    always_comb begin
        sel_desc_c.src_addr  = DESC_ADDR_W'(req_src_addr[32'(grant_id_c)*AW +: AW]);
        sel_desc_c.dest_addr = DESC_ADDR_W'(req_dest_addr[32'(grant_id_c)*AW +: AW]);
        sel_desc_c.x_length  = DESC_LEN_W'(req_x_length[32'(grant_id_c)*LW +: LW]);
        sel_desc_c.last      = req_last[grant_id_c];
    end

    assign eot_pop_c = request_eot && !fifo_empty;

    // Request FSM, EOT routing and the sticky spurious-EOT flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= ID_W'(NUM_REQ - 1);
            desc_q        <= '0;
            request_valid <= 1'b0;
            req_eot       <= '0;
            eot_error     <= 1'b0;
        end else begin
            req_eot <= '0;
            if (eot_pop_c) begin
                req_eot[head_id] <= 1'b1;
            end
            if (request_eot && fifo_empty) begin
                eot_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        desc_q        <= sel_desc_c;
                        last_grant    <= grant_id_c;
                        request_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (request_ready) begin
                        request_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    request_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign request_src_addr  = AW'(desc_q.src_addr);
    assign request_dest_addr = AW'(desc_q.dest_addr);
    assign request_x_length  = LW'(desc_q.x_length);
    assign request_last      = desc_q.last;

    dmac_sched_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (grant_c),
        .push_id (grant_id_c),
        .pop     (eot_pop_c),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding)
    );

endmodule

// File: tb/tb_dmac_request_scheduler.sv
// Self-checking bench for dmac_request_scheduler: grant table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_dmac_request_scheduler;

    localparam int unsigned NR   = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned LW   = 24;
    localparam int unsigned MO   = 4;
    localparam int unsigned NVEC = 12;

    typedef struct packed {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        logic          last;
    } exp_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] ready;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR*AW-1:0]     req_src_addr;
    logic [NR*AW-1:0]     req_dest_addr;
    logic [NR*LW-1:0]     req_x_length;
    logic [NR-1:0]        req_last;
    logic [NR-1:0]        req_eot;
    logic                 request_valid;
    logic                 request_ready;
    logic [AW-1:0]        request_src_addr;
    logic [AW-1:0]        request_dest_addr;
    logic [LW-1:0]        request_x_length;
    logic                 request_last;
    logic                 request_eot;
    logic [$clog2(MO):0]  outstanding;
    logic                 eot_error;

    logic [AW-1:0] src_m [NR];
    logic [AW-1:0] dst_m [NR];
    logic [LW-1:0] len_m [NR];
    logic          last_m [NR];

    exp_t          issue_q [$];
    logic [NR-1:0] eot_q [$];
    vec_t          vecs [NVEC];
    exp_t          mon_e;
    logic [NR-1:0] mon_oh;
    exp_t          hold_e;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    dmac_request_scheduler #(
        .NUM_REQ            (NR),
        .DMA_AXI_ADDR_WIDTH (AW),
        .DMA_LENGTH_WIDTH   (LW),
        .MAX_OUTSTANDING    (MO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_src_addr      (req_src_addr),
        .req_dest_addr     (req_dest_addr),
        .req_x_length      (req_x_length),
        .req_last          (req_last),
        .req_eot           (req_eot),
        .request_valid     (request_valid),
        .request_ready     (request_ready),
        .request_src_addr  (request_src_addr),
        .request_dest_addr (request_dest_addr),
        .request_x_length  (request_x_length),
        .request_last      (request_last),
        .request_eot       (request_eot),
        .outstanding       (outstanding),
        .eot_error         (eot_error)
    );

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_src_addr[i*AW +: AW]  = src_m[i];
            req_dest_addr[i*AW +: AW] = dst_m[i];
            req_x_length[i*LW +: LW]  = len_m[i];
            req_last[i]               = last_m[i];
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t desc_of(input int id);
        exp_t e;
        e.src  = src_m[id];
        e.dst  = dst_m[id];
        e.len  = len_m[id];
        e.last = last_m[id];
        return e;
    endfunction

    function automatic int oh_id(input logic [NR-1:0] oh);
        int r;
        r = 0;
        for (int j = 0; j < NR; j++) begin
            if (oh[j]) r = j;
        end
        return r;
    endfunction

    function automatic logic [95:0] out_desc();
        exp_t e;
        e.src  = request_src_addr;
        e.dst  = request_dest_addr;
        e.len  = request_x_length;
        e.last = request_last;
        return 96'(e);
    endfunction

    // Scoreboard: issued descriptors and routed EOTs are checked against queued expectations.
    always @(negedge clk) begin
        if (!reset && request_valid && request_ready) begin
            if (issue_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_unexpected: got %0h expected no issue at %0t", out_desc(), $time);
            end else begin
                mon_e = issue_q.pop_front();
                chk("issue_desc", out_desc(), 96'(mon_e));
            end
        end
        if (req_eot != '0) begin
            if (eot_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL eot_unexpected: got %0h expected 0 at %0t", req_eot, $time);
            end else begin
                mon_oh = eot_q.pop_front();
                chk("eot_route", 96'(req_eot), 96'(mon_oh));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue_one(input int id);
        logic [NR-1:0] oh;
        oh = NR'(1) << id;
        req_valid = oh;
        @(negedge clk);
        chk("grant_ready", 96'(req_ready), 96'(oh));
        issue_q.push_back(desc_of(id));
        tick();
        req_valid = '0;
        chk("issue_valid", 96'(request_valid), 96'(1));
        request_ready = 1'b1;
        tick();
        request_ready = 1'b0;
    endtask

    task automatic eot_pulse(input int id);
        request_eot = 1'b1;
        eot_q.push_back(NR'(1) << id);
        tick();
        request_eot = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0010, 4'b0010};
        vecs[1]  = '{4'b1111, 4'b0100};
        vecs[2]  = '{4'b1111, 4'b1000};
        vecs[3]  = '{4'b0011, 4'b0001};
        vecs[4]  = '{4'b0001, 4'b0001};
        vecs[5]  = '{4'b1001, 4'b1000};
        vecs[6]  = '{4'b0110, 4'b0010};
        vecs[7]  = '{4'b0000, 4'b0000};
        vecs[8]  = '{4'b1100, 4'b0100};
        vecs[9]  = '{4'b1011, 4'b1000};
        vecs[10] = '{4'b1011, 4'b0001};
        vecs[11] = '{4'b1011, 4'b0010};
        for (int i = 0; i < NR; i++) begin
            src_m[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
            dst_m[i]  = 32'h2000_0000 + 32'(i) * 32'h100;
            len_m[i]  = 24'h000040 + 24'(i);
            last_m[i] = 1'(i);
        end
        req_valid     = '0;
        request_ready = 1'b0;
        request_eot   = 1'b0;
        apply_reset();

        // Reset state
        chk("rst_request_valid", 96'(request_valid), 96'(0));
        chk("rst_request_desc", out_desc(), 96'(0));
        chk("rst_outstanding", 96'(outstanding), 96'(0));
        chk("rst_eot_error", 96'(eot_error), 96'(0));
        chk("rst_req_eot", 96'(req_eot), 96'(0));
        chk("rst_req_ready", 96'(req_ready), 96'(0));

        // Grant table: each row issues from IDLE, is accepted and completed
        for (int v = 0; v < NVEC; v++) begin
            req_valid = vecs[v].valid;
            @(negedge clk);
            chk("tbl_ready", 96'(req_ready), 96'(vecs[v].ready));
            if (vecs[v].ready != '0) begin
                issue_q.push_back(desc_of(oh_id(vecs[v].ready)));
                tick();
                req_valid = '0;
                chk("tbl_valid", 96'(request_valid), 96'(1));
                chk("tbl_outstanding", 96'(outstanding), 96'(1));
                request_ready = 1'b1;
                request_eot   = 1'b1;
                eot_q.push_back(vecs[v].ready);
                tick();
                request_ready = 1'b0;
                request_eot   = 1'b0;
                chk("tbl_drained", 96'(outstanding), 96'(0));
                chk("tbl_valid_drop", 96'(request_valid), 96'(0));
            end else begin
                tick();
                req_valid = '0;
                chk("tbl_no_issue", 96'(request_valid), 96'(0));
            end
        end

        // Single requester with explicit descriptor
        src_m[1]  = 32'h0000_1000;
        dst_m[1]  = 32'h0000_2000;
        len_m[1]  = 24'h0000FF;
        last_m[1] = 1'b1;
        issue_one(1);
        chk("single_outstanding", 96'(outstanding), 96'(1));
        eot_pulse(1);
        @(negedge clk);
        chk("single_req_eot", 96'(req_eot), 96'(4'b0010));
        chk("single_outstanding0", 96'(outstanding), 96'(0));
        tick();

        // Round robin with all requesters valid and ready tied high
        apply_reset();
        req_valid     = 4'b1111;
        request_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 96'(req_ready), 96'(NR'(1) << (k % NR)));
            issue_q.push_back(desc_of(k % NR));
            tick();
            request_eot = 1'b1;
            eot_q.push_back(NR'(1) << (k % NR));
            @(negedge clk);
            chk("rr_spacing", 96'(req_ready), 96'(0));
            tick();
            request_eot = 1'b0;
        end
        req_valid     = '0;
        request_ready = 1'b0;
        tick();

        // Full: four issues without EOT block further grants
        req_valid     = 4'b1111;
        request_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_grant", 96'(req_ready), 96'(NR'(1) << ((k + 1) % NR)));
            issue_q.push_back(desc_of((k + 1) % NR));
            tick();
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_blocked", 96'(req_ready), 96'(0));
            chk("full_outstanding", 96'(outstanding), 96'(MO));
            tick();
        end
        request_eot = 1'b1;
        eot_q.push_back(4'b0010);
        @(negedge clk);
        chk("full_same_cycle_eot", 96'(req_ready), 96'(0));
        tick();
        request_eot = 1'b0;
        @(negedge clk);
        chk("full_after_eot_cnt", 96'(outstanding), 96'(3));
        chk("full_regrant", 96'(req_ready), 96'(4'b0010));
        issue_q.push_back(desc_of(1));
        tick();
        req_valid = '0;
        tick();
        request_ready = 1'b0;
        chk("full_refilled", 96'(outstanding), 96'(MO));
        eot_pulse(2);
        eot_pulse(3);
        eot_pulse(0);
        eot_pulse(1);
        tick();
        chk("full_drained", 96'(outstanding), 96'(0));

        // Backpressure: outputs hold while the requester's inputs change
        src_m[2] = 32'hCAFE_0000;
        dst_m[2] = 32'hBEEF_0000;
        len_m[2] = 24'h000123;
        hold_e = desc_of(2);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("bp_grant", 96'(req_ready), 96'(4'b0100));
        tick();
        for (int k = 0; k < 10; k++) begin
            src_m[2]     = src_m[2] + 32'h40;
            len_m[2]     = len_m[2] + 24'h1;
            req_valid[2] = 1'(k);
            @(negedge clk);
            chk("bp_hold_desc", out_desc(), 96'(hold_e));
            chk("bp_hold_valid", 96'(request_valid), 96'(1));
            chk("bp_no_ready", 96'(req_ready), 96'(0));
            tick();
        end
        req_valid = '0;
        issue_q.push_back(hold_e);
        request_ready = 1'b1;
        tick();
        request_ready = 1'b0;
        tick();
        chk("bp_single_issue", 96'(issue_q.size()), 96'(0));
        chk("bp_valid_drop", 96'(request_valid), 96'(0));
        eot_pulse(2);
        tick();

        // Simultaneous grant and EOT keep the count steady
        issue_one(0);
        issue_one(1);
        chk("sim_pre_count", 96'(outstanding), 96'(2));
        req_valid   = 4'b1000;
        request_eot = 1'b1;
        eot_q.push_back(4'b0001);
        issue_q.push_back(desc_of(3));
        @(negedge clk);
        chk("sim_grant", 96'(req_ready), 96'(4'b1000));
        tick();
        req_valid   = '0;
        request_eot = 1'b0;
        chk("sim_count", 96'(outstanding), 96'(2));
        @(negedge clk);
        chk("sim_head_eot", 96'(req_eot), 96'(4'b0001));
        request_ready = 1'b1;
        tick();
        request_ready = 1'b0;
        eot_pulse(1);
        eot_pulse(3);
        tick();
        chk("sim_drained", 96'(outstanding), 96'(0));

        // Spurious EOT
        request_eot = 1'b1;
        tick();
        request_eot = 1'b0;
        chk("spur_eot_error", 96'(eot_error), 96'(1));
        chk("spur_outstanding", 96'(outstanding), 96'(0));
        @(negedge clk);
        chk("spur_no_req_eot", 96'(req_eot), 96'(0));
        tick();

        // Reset during ISSUE, then a stale EOT
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("rst_mid_valid_pre", 96'(request_valid), 96'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 96'(request_valid), 96'(0));
        chk("rst_mid_desc", out_desc(), 96'(0));
        chk("rst_mid_outstanding", 96'(outstanding), 96'(0));
        chk("rst_mid_eot_error", 96'(eot_error), 96'(0));
        chk("rst_mid_req_eot", 96'(req_eot), 96'(0));
        chk("rst_mid_req_ready", 96'(req_ready), 96'(0));
        request_eot = 1'b1;
        tick();
        request_eot = 1'b0;
        chk("stale_eot_error", 96'(eot_error), 96'(1));
        @(negedge clk);
        chk("stale_no_req_eot", 96'(req_eot), 96'(0));
        tick();
        tick();

        chk("issue_q_empty", 96'(issue_q.size()), 96'(0));
        chk("eot_q_empty", 96'(eot_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmac_request_scheduler.md
Name: dmac_request_scheduler

Overview:
- Shares one axi_dmac transfer-request port between NUM_REQ independent requesters.
- Each requester presents a descriptor: source address, destination address, length and last flag.
- Round-robin arbitration selects one descriptor, holds it on the DMAC request interface until it is accepted, and records the requester ID in an in-order tracking FIFO.
- Each DMAC end-of-transfer (EOT) pulse is routed back to the requester that owns the oldest outstanding transfer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DMA_AXI_ADDR_WIDTH, 32, address width of the src/dest address fields.
- DMA_LENGTH_WIDTH, 24, width of the x_length field (encodes bytes-1).
- MAX_OUTSTANDING, 4, depth of the ID-tracking FIFO; power of 2, 2..16.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester descriptor valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_src_addr  in  NUM_REQ*DMA_AXI_ADDR_WIDTH  flattened source addresses.
- req_dest_addr  in  NUM_REQ*DMA_AXI_ADDR_WIDTH  flattened destination addresses.
- req_x_length  in  NUM_REQ*DMA_LENGTH_WIDTH  flattened lengths.
- req_last  in  NUM_REQ  per-requester last flag.
- req_eot  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- request_valid  out  1  descriptor valid toward the DMAC.
- request_ready  in  1  DMAC accept.
- request_src_addr  out  DMA_AXI_ADDR_WIDTH  issued source address.
- request_dest_addr  out  DMA_AXI_ADDR_WIDTH  issued destination address.
- request_x_length  out  DMA_LENGTH_WIDTH  issued length.
- request_last  out  1  issued last flag.
- request_eot  in  1  DMAC end-of-transfer pulse, in issue order.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  count of issued transfers without EOT.
- eot_error  out  1  sticky flag: EOT received with no outstanding transfer.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE.
- IDLE, grant condition: any req_valid and full==0.
  - The grant goes to the first valid requester, searching upward from last_grant+1 with modulo wrap.
  - req_ready[g] is asserted combinationally in that same cycle.
  - The descriptor is registered into the request_* outputs.
  - last_grant is set to g; g is pushed into the ID FIFO; outstanding is incremented; next state is ISSUE.
- IDLE, no grant: no req_valid, or full==1 → req_ready = 0 and the FSM stays in IDLE.
- ISSUE:
  - request_valid = 1 and all request_* outputs are held stable.
  - request_ready=1 → IDLE in the next cycle, with request_valid deasserted.
- Throughput and latency:
  - Peak rate is one issue per 2 cycles.
  - Latency from req_valid (with IDLE, not full) to request_valid is 1 cycle.
- full: outstanding == MAX_OUTSTANDING, taken from the registered count. An EOT arriving in the same cycle does not unblock a grant in that cycle.
- EOT handling:
  - request_eot with FIFO non-empty → pop the head ID h and pulse req_eot[h] in the next cycle (1-cycle registered latency).
  - Then outstanding is decremented.
- Simultaneous push and pop in one cycle: outstanding is unchanged and both FIFO pointers advance.
- request_eot with FIFO empty:
  - eot_error is set and stays set until reset.
  - No req_eot is pulsed and the counters are unchanged.
- FIFO pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally.
- outstanding never exceeds MAX_OUTSTANDING.
- The requester must hold req_valid and its descriptor stable until req_ready. Deasserting early is legal; the descriptor is simply not taken.
- Reset mid-operation:
  - FSM, FIFO, counters and eot_error are cleared and request_valid drops the next cycle.
  - An EOT arriving after reset for a pre-reset transfer sets eot_error. System reset is expected to reset the DMAC together with this block.
- Arithmetic: descriptor fields pass through unmodified. The block never inspects or checks lengths or addresses.

Decomposition:
- Package dmac_sched_pkg holds:
  - the state enum typedef {IDLE, ISSUE};
  - a parameterised descriptor struct (src_addr, dest_addr, x_length, last), sized by constants matching the DMAC parameter set's DMA_AXI_ADDR_WIDTH and DMA_LENGTH_WIDTH.
- One sub-module, dmac_sched_id_fifo:
  - synchronous FIFO of $clog2(NUM_REQ)-bit IDs;
  - push, pop, full, empty, count ports;
  - simultaneous push/pop supported.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single requester: requester 1 valid, src=0x1000, dest=0x2000, len=0xFF → req_ready[1] in cycle 0; request_valid in cycle 1 with identical fields. Then request_ready; request_eot → req_eot = 4'b0010 one cycle later; outstanding returns to 0.
- Round robin: all 4 valid continuously, request_ready tied high → grant order 0,1,2,3,0 at 2-cycle spacing. EOTs pulsed in order → req_eot order 0,1,2,3.
- Full: MAX_OUTSTANDING=4, no EOTs → after 4 issues req_ready stays 0 and outstanding=4. One EOT → outstanding=3, and the next grant happens no earlier than the cycle after.
- Backpressure: request_ready held low for 10 cycles while the requester's inputs change → request_* outputs stable for all 10 cycles; exactly one issue once ready rises.
- Simultaneous push/pop: outstanding=2, grant and request_eot in the same cycle → outstanding stays 2 and the correct head ID is pulsed.
- Spurious EOT and reset: request_eot with outstanding=0 → eot_error=1 and no req_eot. Reset asserted during ISSUE → all outputs 0 the next cycle and eot_error cleared.
